// File: rtl/hydro_frame_axis_tx.sv
// hydro_frame_axis_tx
// AXI-Stream master carrying 4-channel hydrophone sample frames to the downstream max-finder.
// A frame is 4 x SAMPLE_W samples {ch3,ch2,ch1,ch0}. It is sent as two beats:
//   beat0 = {ch1,ch0} with tlast=0, then beat1 = {ch3,ch2} with tlast=1.
// ADC strobes cannot be stalled. A FIFO_DEPTH-entry FIFO plus the frame register absorb
// downstream stalls. A strobe that arrives while the FIFO is full is dropped and counted.
//
// Ports
//   m_axis_aclk    clock, rising edge
//   m_axis_areset  asynchronous active-high reset
//   en             intake enable; with en=0 strobes are ignored, but queued frames still drain
//   smp_valid      one-cycle strobe qualifying smp_data
//   smp_data       {ch3,ch2,ch1,ch0}
//   smp_ready      en && !fifo_full (informational only)
//   m_axis_tvalid / m_axis_tready / m_axis_tdata / m_axis_tlast   AXI-Stream master
//   frame_count    frames fully sent (counts beat1 handshakes), wraps
//   drop_count     strobes lost to a full FIFO while en=1, wraps
//   o_dbg_state    current FSM state (0 IDLE, 1 BEAT0, 2 BEAT1)
//
// Handshake: a beat moves on a rising edge where tvalid && tready. Once tvalid is high,
// tvalid/tdata/tlast hold until that beat moves. tvalid is never withdrawn before then.
module hydro_frame_axis_tx #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLE_W             = 16,
  parameter int FIFO_DEPTH           = 4,
  parameter int CNT_W                = 32
) (
  input  logic                            m_axis_aclk,
  input  logic                            m_axis_areset,
  input  logic                            en,
  input  logic                            smp_valid,
  input  logic [4*SAMPLE_W-1:0]           smp_data,
  output logic                            smp_ready,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [CNT_W-1:0]                frame_count,
  output logic [CNT_W-1:0]                drop_count,
  output logic [1:0]                      o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = 4 * SAMPLE_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [FW-1:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [FW-1:0]     r_frame;
  logic [CNT_W-1:0]  r_frame_count;
  logic [CNT_W-1:0]  r_drop_count;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_load;
  logic              w_hs;
  logic              w_drop;
  logic              w_frame_done;

  // The pointers carry one extra wrap bit. Equal pointers mean empty. Pointers that differ
  // only in the wrap bit mean full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // smp_ready uses the current full flag. A pop in the same cycle does not free a slot.
  // It is also held low while reset is asserted.
  assign smp_ready    = en && !w_full && !m_axis_areset;
  assign w_push       = smp_valid && smp_ready;
  assign w_drop       = smp_valid && en && w_full;
  assign w_hs         = m_axis_tvalid && m_axis_tready;
  assign w_frame_done = (r_state == S_BEAT1) && w_hs;

  // The frame register reloads straight from the FIFO head, either from idle or
  // immediately after a beat1 handshake. This keeps frames back-to-back with no gap.
  assign w_load = !w_empty && ((r_state == S_IDLE) || w_frame_done);

  // FSM state register
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) r_state <= S_IDLE;
    else               r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next_state = S_BEAT0;
      S_BEAT0: if (w_hs)     w_next_state = S_BEAT1;
      S_BEAT1: if (w_hs)     w_next_state = w_empty ? S_IDLE : S_BEAT0;
      default:               w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    case (r_state)
      S_BEAT0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = r_frame[2*SAMPLE_W-1:0];
      end
      S_BEAT1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = r_frame[4*SAMPLE_W-1:2*SAMPLE_W];
      end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

  // FIFO storage. It has no reset, because only entries between the pointers are ever read.
  always_ff @(posedge m_axis_aclk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= smp_data;
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset)  r_frame <= '0;
    else if (w_load)    r_frame <= r_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      r_frame_count <= '0;
      r_drop_count  <= '0;
    end else begin
      if (w_frame_done) r_frame_count <= r_frame_count + CNT_W'(1);
      if (w_drop)       r_drop_count  <= r_drop_count + CNT_W'(1);
    end
  end

  assign frame_count = r_frame_count;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_hydro_frame_axis_tx.sv
module tb_hydro_frame_axis_tx;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        smp_valid = 1'b0;
  logic [63:0] smp_data = '0;
  logic        tready = 1'b0;
  logic        smp_ready;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic [31:0] frame_count;
  logic [31:0] drop_count;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  hydro_frame_axis_tx #(
    .C_M_AXIS_TDATA_WIDTH(32), .SAMPLE_W(16), .FIFO_DEPTH(DEPTH), .CNT_W(32)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .en            (en),
    .smp_valid     (smp_valid),
    .smp_data      (smp_data),
    .smp_ready     (smp_ready),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tlast  (tlast),
    .frame_count   (frame_count),
    .drop_count    (drop_count),
    .o_dbg_state   (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // The model tracks three things: how many frames wait in the buffer, whether a frame
  // is currently being sent and which beat it is on, and the two counters.
  // Each accepted frame pushes its two expected beats {tlast,tdata} into exp_q.
  logic [32:0] exp_q[$];
  int          m_cnt = 0;
  bit          m_busy = 0;
  int          m_beat = 0;
  logic [31:0] m_frames = '0;
  logic [31:0] m_drops = '0;

  // Evaluated on the falling edge: inputs are stable, and the next rising edge applies them.
  always @(negedge clk) begin
    bit full_pre;
    if (rst) begin
      exp_q.delete();
      m_cnt = 0; m_busy = 0; m_beat = 0; m_frames = '0; m_drops = '0;
    end else begin
      full_pre = (m_cnt >= DEPTH);
      chk("tvalid", tvalid, m_busy);
      chk("smp_ready", smp_ready, en && !full_pre);
      chk("frame_count", frame_count, m_frames);
      chk("drop_count", drop_count, m_drops);
      if (tvalid) begin
        if (exp_q.size() > 0) chk("beat", {tlast, tdata}, exp_q[0]);
        else                  chk("beat_unexpected", 1, 0);
        if (tready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      // advance the model to the state after the next rising edge
      if (m_busy && tready) begin
        if (m_beat == 1) begin m_frames++; m_busy = 0; end
        else m_beat = 1;
      end
      if (!m_busy && m_cnt > 0) begin
        m_cnt--; m_busy = 1; m_beat = 0;
      end
      if (smp_valid && en) begin
        if (!full_pre) begin
          m_cnt++;
          exp_q.push_back({1'b0, smp_data[31:0]});
          exp_q.push_back({1'b1, smp_data[63:32]});
        end else m_drops++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; smp_valid = 1'b0; step(2);
    rst = 1'b0; step(1);
  endtask

  task automatic strobe(input logic [63:0] d);
    smp_data = d; smp_valid = 1'b1; step(1);
    smp_valid = 1'b0; step(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // reset values
    en = 1'b1; tready = 1'b1;
    step(1);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_smp_ready", smp_ready, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0; step(1);

    // 1: single frame, tready=1
    strobe(64'h4444_3333_2222_1111);
    step(4);
    chk("t1_frame_count", frame_count, 1);

    // 2: stall during beat0
    do_reset();
    tready = 1'b0;
    strobe(64'h8888_7777_6666_5555);
    step(5);
    chk("t2_hold_tvalid", tvalid, 1);
    chk("t2_hold_tdata", tdata, 32'h6666_5555);
    chk("t2_hold_tlast", tlast, 0);
    tready = 1'b1;
    step(4);
    chk("t2_frame_count", frame_count, 1);

    // 3: overflow with tready=0
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 5; i++) strobe({16'(i), 16'hA3, 16'hA2, 16'hA1} + 64'(i));
    chk("t3_ready_at_6th", smp_ready, 0);
    strobe(64'hDEAD_DEAD_DEAD_DEAD);
    chk("t3_drop_count", drop_count, 1);
    tready = 1'b1;
    step(14);
    chk("t3_frame_count", frame_count, 5);

    // 4: en=0 ignores strobes
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 3; i++) strobe({$urandom, $urandom});
    chk("t4_tvalid", tvalid, 0);
    chk("t4_drop_count", drop_count, 0);
    chk("t4_smp_ready", smp_ready, 0);
    en = 1'b1;

    // 5: reset during beat1
    do_reset();
    tready = 1'b1;
    smp_data = 64'h1234_5678_9ABC_DEF0; smp_valid = 1'b1; step(1); smp_valid = 1'b0;
    n = 0;
    while (!(tvalid && tlast) && n < 20) begin step(1); n++; end
    chk("t5_reach_beat1", n < 20, 1);
    rst = 1'b1; #1;
    chk("t5_tvalid", tvalid, 0);
    chk("t5_tlast", tlast, 0);
    chk("t5_frame_count", frame_count, 0);
    chk("t5_drop_count", drop_count, 0);
    step(1); rst = 1'b0; step(6);
    chk("t5_no_beats", tvalid, 0);

    // 6: sustained rate
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 100; i++) strobe({$urandom, $urandom});
    step(6);
    chk("t6_frame_count", frame_count, 100);
    chk("t6_drop_count", drop_count, 0);

    // 7: randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      en        = ($urandom_range(0, 7) != 0);
      smp_valid = ($urandom_range(0, 2) == 0);
      smp_data  = {$urandom, $urandom};
      tready    = ($urandom_range(0, 3) != 0);
      step(1);
    end
    smp_valid = 1'b0; en = 1'b0; tready = 1'b1;
    step(30);
    chk("t7_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
